// File: rtl/opendap_ap_mux.sv
// AP access-port mux: routes one DP AP access to N_APS downstream APs and sequences the transfer.
// Optional WAIT timeout with per-AP abort is enabled by defining OPENDAP_AP_MUX_TIMEOUT_EN.
module opendap_ap_mux #(
    parameter int N_APS   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                  swclk,
    input  logic                  rst,
    input  logic [7:0]            ap_sel,
    input  logic [5:0]            ap_addr,
    input  logic [31:0]           ap_wdata,
    input  logic                  ap_wen,
    input  logic                  ap_ren,
    input  logic                  ap_abort,
    output logic [31:0]           ap_rdata,
    output logic                  ap_rdy,
    output logic                  ap_err,
    output logic [5:0]            dn_addr,
    output logic [31:0]           dn_wdata,
    output logic [N_APS-1:0]      dn_wen,
    output logic [N_APS-1:0]      dn_ren,
    output logic [N_APS-1:0]      dn_abort,
    input  logic [32*N_APS-1:0]   dn_rdata,
    input  logic [N_APS-1:0]      dn_rdy,
    input  logic [N_APS-1:0]      dn_err
);

    // Handshake: upstream may pulse ap_wen/ap_ren only while ap_rdy is high; ap_rdy dropping
    // acknowledges the request, and ap_rdy rising again marks ap_rdata/ap_err valid. Downstream
    // strobes are single-cycle; the selected AP answers with dn_rdy/dn_err/dn_rdata in WAIT.
    localparam int IW = (N_APS > 1) ? $clog2(N_APS) : 1;

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, ERR} state_t;

    state_t            state, state_d;
    logic [IW-1:0]     idx, idx_d;
    logic              wr, wr_d;
    logic [5:0]        addr_d;
    logic [31:0]       wdata_d, rdata_d;
    logic              rdy_d, err_d;
    logic [N_APS-1:0]  wen_d, ren_d, abort_d;
    logic [N_APS-1:0]  sel_hot, idx_hot;
    logic [31:0]       cur_rdata;
    logic              cur_rdy, cur_err;
    logic              mapped;

`ifdef OPENDAP_AP_MUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt, tmo_cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^32'(TIMEOUT);
`endif

    assign mapped = ({1'b0, ap_sel} < 9'(N_APS));

    // Decode the incoming select and mux the latched AP's response.
    always_comb begin
        sel_hot   = '0;
        idx_hot   = '0;
        cur_rdata = '0;
        cur_rdy   = 1'b0;
        cur_err   = 1'b0;
        for (int i = 0; i < N_APS; i++) begin
            sel_hot[i] = (ap_sel == 8'(i));
            idx_hot[i] = (idx == IW'(i));
            if (idx == IW'(i)) begin
                cur_rdata = dn_rdata[32*i +: 32];
                cur_rdy   = dn_rdy[i];
                cur_err   = dn_err[i];
            end
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        wr_d    = wr;
        addr_d  = dn_addr;
        wdata_d = dn_wdata;
        rdata_d = ap_rdata;
        rdy_d   = ap_rdy;
        err_d   = ap_err;
        wen_d   = '0;
        ren_d   = '0;
        abort_d = '0;
`ifdef OPENDAP_AP_MUX_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt;
`endif
        if (ap_abort) begin
            // Abort beats everything, including a request strobe in the same cycle.
            state_d = IDLE;
            rdy_d   = 1'b1;
            err_d   = 1'b0;
            abort_d = '1;
        end else begin
            case (state)
                IDLE: begin
                    if (ap_wen || ap_ren) begin
                        addr_d  = ap_addr;
                        wdata_d = ap_wdata;
                        idx_d   = ap_sel[IW-1:0];
                        wr_d    = ap_wen;
                        err_d   = 1'b0;
                        rdy_d   = 1'b0;
                        if (mapped) begin
                            state_d = STROBE;
                            wen_d   = ap_wen ? sel_hot : '0;
                            ren_d   = ap_wen ? '0 : sel_hot;
                        end else begin
                            state_d = ERR;
                        end
                    end
                end
                STROBE: begin
                    state_d = WAIT;
`ifdef OPENDAP_AP_MUX_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
                WAIT: begin
                    if (cur_rdy) begin
                        if (!wr) rdata_d = cur_rdata;
                        err_d   = cur_err;
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end
`ifdef OPENDAP_AP_MUX_TIMEOUT_EN
                    else if (tmo_cnt == CW'(TIMEOUT)) begin
                        abort_d = idx_hot;
                        rdata_d = '0;
                        err_d   = 1'b1;
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt + 1'b1;
                    end
`endif
                end
                ERR: begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge swclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            wr       <= 1'b0;
            dn_addr  <= '0;
            dn_wdata <= '0;
            ap_rdata <= '0;
            ap_rdy   <= 1'b1;
            ap_err   <= 1'b0;
            dn_wen   <= '0;
            dn_ren   <= '0;
            dn_abort <= '0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            wr       <= wr_d;
            dn_addr  <= addr_d;
            dn_wdata <= wdata_d;
            ap_rdata <= rdata_d;
            ap_rdy   <= rdy_d;
            ap_err   <= err_d;
            dn_wen   <= wen_d;
            dn_ren   <= ren_d;
            dn_abort <= abort_d;
        end
    end

`ifdef OPENDAP_AP_MUX_TIMEOUT_EN
    always_ff @(posedge swclk or posedge rst) begin
        if (rst) tmo_cnt <= '0;
        else     tmo_cnt <= tmo_cnt_d;
    end
`endif

endmodule

// File: tb/tb_opendap_ap_mux.sv
// Directed bench for opendap_ap_mux: vector table of single transfers plus hand-written
// sequences for downstream wait, abort, timeout and mid-transfer reset.
module tb_opendap_ap_mux;
    logic         swclk = 1'b0;
    logic         rst;
    logic [7:0]   ap_sel;
    logic [5:0]   ap_addr;
    logic [31:0]  ap_wdata;
    logic         ap_wen, ap_ren, ap_abort;
    logic [31:0]  ap_rdata;
    logic         ap_rdy, ap_err;
    logic [5:0]   dn_addr;
    logic [31:0]  dn_wdata;
    logic [3:0]   dn_wen, dn_ren, dn_abort;
    logic [127:0] dn_rdata;
    logic [3:0]   dn_rdy, dn_err;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  sel;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic        wen;
        logic        ren;
        logic        err_in;
        logic        map;
        logic [3:0]  exp_wen;
        logic [3:0]  exp_ren;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    opendap_ap_mux #(.N_APS(4), .TIMEOUT(8)) dut (
        .swclk(swclk), .rst(rst), .ap_sel(ap_sel), .ap_addr(ap_addr), .ap_wdata(ap_wdata),
        .ap_wen(ap_wen), .ap_ren(ap_ren), .ap_abort(ap_abort), .ap_rdata(ap_rdata),
        .ap_rdy(ap_rdy), .ap_err(ap_err), .dn_addr(dn_addr), .dn_wdata(dn_wdata),
        .dn_wen(dn_wen), .dn_ren(dn_ren), .dn_abort(dn_abort), .dn_rdata(dn_rdata),
        .dn_rdy(dn_rdy), .dn_err(dn_err)
    );

    always #5 swclk = ~swclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge swclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        for (int i = 0; i < 4; i++) dn_err[i] = (v.sel == 8'(i)) ? v.err_in : !v.err_in;
        ap_sel = v.sel; ap_addr = v.addr; ap_wdata = v.wdata;
        ap_wen = v.wen; ap_ren = v.ren;
        tick();
        ap_wen = 1'b0; ap_ren = 1'b0;
        chk({tag, "_wen"},   32'(dn_wen),   32'(v.exp_wen));
        chk({tag, "_ren"},   32'(dn_ren),   32'(v.exp_ren));
        chk({tag, "_addr"},  32'(dn_addr),  32'(v.addr));
        chk({tag, "_wdata"}, dn_wdata,      v.wdata);
        chk({tag, "_busy"},  32'(ap_rdy),   32'd0);
        if (v.map) begin
            tick();
            chk({tag, "_stb_off"}, 32'(dn_wen | dn_ren), 32'd0);
            chk({tag, "_busy2"},   32'(ap_rdy),          32'd0);
        end
        tick();
        chk({tag, "_rdy"},   32'(ap_rdy),   32'd1);
        chk({tag, "_err"},   32'(ap_err),   32'(v.exp_err));
        chk({tag, "_rdata"}, ap_rdata,      v.exp_rdata);
        chk({tag, "_abort"}, 32'(dn_abort), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},   32'(ap_rdy),   32'd1);
        chk({tag, "_err"},   32'(ap_err),   32'd0);
        chk({tag, "_rdata"}, ap_rdata,      32'd0);
        chk({tag, "_addr"},  32'(dn_addr),  32'd0);
        chk({tag, "_wdata"}, dn_wdata,      32'd0);
        chk({tag, "_dnstb"}, 32'({dn_wen, dn_ren, dn_abort}), 32'd0);
    endtask

    initial begin
        vec_t v;
        // sel, addr, wdata, wen, ren, err_in, map, exp_wen, exp_ren, exp_rdata, exp_err
        vecs[0] = '{8'h02, 6'h04, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0100, 32'h12345678, 1'b0};
        vecs[1] = '{8'h01, 6'h3F, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0000, 32'h12345678, 1'b0};
        vecs[2] = '{8'h00, 6'h00, 32'h00000001, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0001, 32'hA0A00000, 1'b1};
        vecs[3] = '{8'h07, 6'h10, 32'h00000002, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b1};
        vecs[4] = '{8'h03, 6'h2A, 32'h00000003, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 32'h33333333, 1'b0};
        vecs[5] = '{8'h04, 6'h11, 32'h55AA55AA, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b1};
        vecs[6] = '{8'h01, 6'h01, 32'h00000004, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0010, 32'h11111111, 1'b0};
        vecs[7] = '{8'h03, 6'h22, 32'h0BADF00D, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b0000, 32'h11111111, 1'b0};
        vecs[8] = '{8'hFF, 6'h05, 32'h00000005, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b1};

        // Clock/reset
        rst = 1'b1;
        ap_sel = '0; ap_addr = '0; ap_wdata = '0;
        ap_wen = 1'b0; ap_ren = 1'b0; ap_abort = 1'b0;
        dn_rdata = {32'h33333333, 32'h12345678, 32'h11111111, 32'hA0A00000};
        dn_rdy = 4'b1111; dn_err = 4'b0000;
        tick(); tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Write to AP 0 with five downstream wait cycles and an error response.
        v = '{8'h03, 6'h00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 32'h33333333, 1'b0};
        run_vec("pre_wait", v);
        ap_sel = 8'h00; ap_addr = 6'h0C; ap_wdata = 32'hCAFEF00D; ap_wen = 1'b1;
        tick();
        ap_wen = 1'b0;
        chk("wait_wen", 32'(dn_wen), 32'b0001);
        chk("wait_addr", 32'(dn_addr), 32'h0C);
        chk("wait_wdata", dn_wdata, 32'hCAFEF00D);
        dn_rdy[0] = 1'b0; dn_err = 4'b0001;
        for (int k = 2; k <= 7; k++) begin
            tick();
            chk($sformatf("wait_busy_c%0d", k), 32'(ap_rdy), 32'd0);
        end
        dn_rdy[0] = 1'b1;
        tick();
        chk("wait_rdy_c8", 32'(ap_rdy), 32'd1);
        chk("wait_err_c8", 32'(ap_err), 32'd1);
        chk("wait_rdata_c8", ap_rdata, 32'h33333333);
        dn_err = 4'b0000;

        // Abort while waiting on AP 1.
        dn_rdy[1] = 1'b0;
        ap_sel = 8'h01; ap_ren = 1'b1;
        tick();
        ap_ren = 1'b0;
        chk("abw_ren", 32'(dn_ren), 32'b0010);
        tick();
        chk("abw_busy", 32'(ap_rdy), 32'd0);
        ap_abort = 1'b1;
        tick();
        ap_abort = 1'b0;
        chk("abw_abort", 32'(dn_abort), 32'b1111);
        chk("abw_rdy", 32'(ap_rdy), 32'd1);
        chk("abw_err", 32'(ap_err), 32'd0);
        chk("abw_rdata", ap_rdata, 32'h33333333);
        tick();
        chk("abw_abort_off", 32'(dn_abort), 32'd0);
        chk("abw_rdy2", 32'(ap_rdy), 32'd1);
        dn_rdy = 4'b1111;

        // Abort together with a read strobe: the read is dropped.
        run_vec("pre_sim", vecs[3]);
        ap_sel = 8'h02; ap_ren = 1'b1; ap_abort = 1'b1;
        tick();
        ap_ren = 1'b0; ap_abort = 1'b0;
        chk("sim_abort", 32'(dn_abort), 32'b1111);
        chk("sim_ren", 32'(dn_ren), 32'd0);
        chk("sim_rdy", 32'(ap_rdy), 32'd1);
        chk("sim_err", 32'(ap_err), 32'd0);
        for (int k = 2; k <= 3; k++) begin
            tick();
            chk($sformatf("sim_quiet_c%0d", k), 32'({dn_ren, dn_wen, dn_abort}), 32'd0);
            chk($sformatf("sim_rdy_c%0d", k), 32'(ap_rdy), 32'd1);
        end

        // AP 3 never answers.
        run_vec("pre_tmo", vecs[0]);
        dn_rdy[3] = 1'b0;
        ap_sel = 8'h03; ap_ren = 1'b1;
        tick();
        ap_ren = 1'b0;
        chk("tmo_ren", 32'(dn_ren), 32'b1000);
`ifdef OPENDAP_AP_MUX_TIMEOUT_EN
        for (int k = 2; k <= 10; k++) begin
            tick();
            chk($sformatf("tmo_busy_c%0d", k), 32'(ap_rdy), 32'd0);
            chk($sformatf("tmo_noabort_c%0d", k), 32'(dn_abort), 32'd0);
        end
        tick();
        chk("tmo_abort", 32'(dn_abort), 32'b1000);
        chk("tmo_rdy", 32'(ap_rdy), 32'd1);
        chk("tmo_err", 32'(ap_err), 32'd1);
        chk("tmo_rdata", ap_rdata, 32'd0);
        tick();
        chk("tmo_abort_off", 32'(dn_abort), 32'd0);
`else
        for (int k = 2; k <= 20; k++) begin
            tick();
            chk($sformatf("notmo_busy_c%0d", k), 32'(ap_rdy), 32'd0);
        end
        ap_abort = 1'b1;
        tick();
        ap_abort = 1'b0;
        chk("notmo_abort", 32'(dn_abort), 32'b1111);
        chk("notmo_rdy", 32'(ap_rdy), 32'd1);
        chk("notmo_rdata", ap_rdata, 32'h12345678);
        tick();
`endif
        dn_rdy = 4'b1111;

        // Reset asserted while waiting on AP 1.
        run_vec("pre_rst", vecs[6]);
        dn_rdy[1] = 1'b0;
        ap_sel = 8'h01; ap_addr = 6'h15; ap_wdata = 32'hFFFF0000; ap_ren = 1'b1;
        tick();
        ap_ren = 1'b0;
        tick();
        chk("rst_busy", 32'(ap_rdy), 32'd0);
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst_async");
        tick();
        chk_reset_vals("rst_held");
        #2 rst = 1'b0;
        dn_rdy = 4'b1111;
        tick();
        run_vec("post_rst", vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
